// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: bus commands,
// requester identity and the per-tag ownership record.
package mem_arbiter_pkg;

    localparam int MEM_TAG_W        = 4;
    localparam int MEM_ADDR_W       = 32;
    localparam int MEM_DATA_W       = 64;
    localparam int MEM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   squashed;
    } tag_entry_t;

    function automatic logic is_request(input bus_command_e cmd);
        return cmd != BUS_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two cache controllers, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W  = MEM_TAG_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    bus_command_e              proc2Imem_command;
    logic         [ADDR_W-1:0] proc2Imem_addr;
    bus_command_e              proc2Dmem_command;
    logic         [ADDR_W-1:0] proc2Dmem_addr;
    logic         [DATA_W-1:0] proc2Dmem_data;
    logic                      squash_imem;

    logic         [TAG_W-1:0]  mem2proc_response;
    logic         [DATA_W-1:0] mem2proc_data;
    logic         [TAG_W-1:0]  mem2proc_tag;

    bus_command_e              proc2mem_command;
    logic         [ADDR_W-1:0] proc2mem_addr;
    logic         [DATA_W-1:0] proc2mem_data;

    logic         [TAG_W-1:0]  Imem2proc_response;
    logic         [DATA_W-1:0] Imem2proc_data;
    logic         [TAG_W-1:0]  Imem2proc_tag;
    logic         [TAG_W-1:0]  Dmem2proc_response;
    logic         [DATA_W-1:0] Dmem2proc_data;
    logic         [TAG_W-1:0]  Dmem2proc_tag;
    logic                      orphan_tag_err;

    modport slave (
        input  proc2Imem_command, proc2Imem_addr,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  squash_imem,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output orphan_tag_err
    );

    modport master (
        output proc2Imem_command, proc2Imem_addr,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output squash_imem,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  orphan_tag_err
    );

endinterface

// File: rtl/mem_tag_table.sv
// Per-tag ownership table: records which requester owns each outstanding load
// tag, retires entries as data returns, and can squash all I-side entries at once.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_tag,
    input  owner_e           alloc_owner,
    input  logic             ret_valid,
    input  logic [TAG_W-1:0] ret_tag,
    output tag_entry_t       ret_entry,
    input  logic             squash_i
);

    localparam int NUM_TAGS = 1 << TAG_W;

    // Kept in flops rather than RAM: squash touches every entry in one cycle.
    tag_entry_t entries [NUM_TAGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_slot
            tag_entry_t slot_q;
            tag_entry_t slot_d;

            always_comb begin
                slot_d = slot_q;
                if (squash_i && slot_q.valid && (slot_q.owner == OWN_I)) begin
                    slot_d.squashed = 1'b1;
                end
                if (ret_valid && (ret_tag == TAG_W'(gi))) begin
                    slot_d = '0;
                end
                // A new allocation overrides a same-cycle retire of the old owner.
                if (alloc_valid && (alloc_tag == TAG_W'(gi))) begin
                    slot_d.valid    = 1'b1;
                    slot_d.owner    = alloc_owner;
                    slot_d.squashed = squash_i && (alloc_owner == OWN_I);
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign entries[gi] = slot_q;
        end
    endgenerate

    assign ret_entry = entries[ret_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between I-fetch and D-access, with a forced
// I-grant after a run of denials, and steers returning beats to their owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W        = MEM_TAG_W,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic             i_req;
    logic             d_req;
    logic             force_i;
    logic             grant_i;
    logic             grant_d;
    bus_command_e     grant_cmd;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             orphan_err_q;
    logic             orphan_err_d;

    logic             alloc_valid;
    owner_e           alloc_owner;
    logic             ret_valid;
    tag_entry_t       ret_entry;
    logic             deliver;

    always_comb begin
        i_req   = (bus.proc2Imem_command == BUS_LOAD);
        d_req   = is_request(bus.proc2Dmem_command);
        force_i = i_req && (starve_cnt_q == STARVE_MAX);
        grant_d = d_req && !force_i;
        grant_i = i_req && !grant_d;
    end

    always_comb begin
        grant_cmd = BUS_NONE;
        if (grant_d) begin
            grant_cmd = bus.proc2Dmem_command;
        end else if (grant_i) begin
            grant_cmd = BUS_LOAD;
        end
    end

    // Stores are forwarded but never tracked: nothing comes back for them.
    assign alloc_valid = !reset && (grant_cmd == BUS_LOAD) && (bus.mem2proc_response != '0);
    assign alloc_owner = grant_i ? OWN_I : OWN_D;
    assign ret_valid   = (bus.mem2proc_tag != '0);
    assign deliver     = ret_valid && ret_entry.valid && !ret_entry.squashed;

    mem_tag_table #(
        .TAG_W (TAG_W)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_tag   (bus.mem2proc_response),
        .alloc_owner (alloc_owner),
        .ret_valid   (ret_valid),
        .ret_tag     (bus.mem2proc_tag),
        .ret_entry   (ret_entry),
        .squash_i    (bus.squash_imem)
    );

    always_comb begin
        bus.proc2mem_command   = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Imem2proc_response = '0;
        bus.Dmem2proc_response = '0;
        if (!reset) begin
            if (grant_d) begin
                bus.proc2mem_command   = bus.proc2Dmem_command;
                bus.proc2mem_addr      = bus.proc2Dmem_addr;
                bus.proc2mem_data      = bus.proc2Dmem_data;
                bus.Dmem2proc_response = bus.mem2proc_response;
            end else if (grant_i) begin
                bus.proc2mem_command   = BUS_LOAD;
                bus.proc2mem_addr      = bus.proc2Imem_addr;
                bus.Imem2proc_response = bus.mem2proc_response;
            end
        end
    end

    always_comb begin
        bus.Imem2proc_data = '0;
        bus.Imem2proc_tag  = '0;
        bus.Dmem2proc_data = '0;
        bus.Dmem2proc_tag  = '0;
        if (!reset && deliver) begin
            if (ret_entry.owner == OWN_I) begin
                bus.Imem2proc_data = bus.mem2proc_data;
                bus.Imem2proc_tag  = bus.mem2proc_tag;
            end else begin
                bus.Dmem2proc_data = bus.mem2proc_data;
                bus.Dmem2proc_tag  = bus.mem2proc_tag;
            end
        end
    end

    assign bus.orphan_tag_err = orphan_err_q && !reset;

    always_comb begin
        starve_cnt_d = '0;
        if (i_req && !grant_i) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                        : starve_cnt_q + CNT_W'(1);
        end
        orphan_err_d = orphan_err_q || (ret_valid && !ret_entry.valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            orphan_err_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            orphan_err_q <= orphan_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: each record is one cycle of inputs plus
// the hand-computed outputs expected in that cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TAG_W  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef struct {
        logic         rst;
        bus_command_e i_cmd;
        logic [31:0]  i_addr;
        bus_command_e d_cmd;
        logic [31:0]  d_addr;
        logic [63:0]  d_data;
        logic         squash;
        logic [3:0]   resp;
        logic [3:0]   rtag;
        logic [63:0]  rdata;
        bus_command_e e_cmd;
        logic [31:0]  e_addr;
        logic [63:0]  e_data;
        logic [3:0]   e_iresp;
        logic [3:0]   e_dresp;
        logic [63:0]  e_idata;
        logic [3:0]   e_itag;
        logic [63:0]  e_ddata;
        logic [3:0]   e_dtag;
        logic         e_err;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .TAG_W        (TAG_W),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clock);
        reset                 = v.rst;
        bus.proc2Imem_command = v.i_cmd;
        bus.proc2Imem_addr    = v.i_addr;
        bus.proc2Dmem_command = v.d_cmd;
        bus.proc2Dmem_addr    = v.d_addr;
        bus.proc2Dmem_data    = v.d_data;
        bus.squash_imem       = v.squash;
        bus.mem2proc_response = v.resp;
        bus.mem2proc_tag      = v.rtag;
        bus.mem2proc_data     = v.rdata;
        #2;
        chk("bus_cmd",   idx, 64'(bus.proc2mem_command),   64'(v.e_cmd));
        chk("bus_addr",  idx, 64'(bus.proc2mem_addr),      64'(v.e_addr));
        chk("bus_data",  idx, bus.proc2mem_data,           v.e_data);
        chk("i_resp",    idx, 64'(bus.Imem2proc_response), 64'(v.e_iresp));
        chk("d_resp",    idx, 64'(bus.Dmem2proc_response), 64'(v.e_dresp));
        chk("i_data",    idx, bus.Imem2proc_data,          v.e_idata);
        chk("i_tag",     idx, 64'(bus.Imem2proc_tag),      64'(v.e_itag));
        chk("d_data",    idx, bus.Dmem2proc_data,          v.e_ddata);
        chk("d_tag",     idx, 64'(bus.Dmem2proc_tag),      64'(v.e_dtag));
        chk("orphan",    idx, 64'(bus.orphan_tag_err),     64'(v.e_err));
        $display("step %0d: rst=%0b cmd=%0d addr=%h iresp=%0d dresp=%0d itag=%0d dtag=%0d err=%0b errors=%0d",
                 idx, v.rst, bus.proc2mem_command, bus.proc2mem_addr, bus.Imem2proc_response,
                 bus.Dmem2proc_response, bus.Imem2proc_tag, bus.Dmem2proc_tag, bus.orphan_tag_err, errors);
    endtask

    localparam bus_command_e N = BUS_NONE;
    localparam bus_command_e L = BUS_LOAD;
    localparam bus_command_e S = BUS_STORE;

    vec_t vecs[$];
    vec_t hand[$];

    initial begin
        checks = 0;
        errors = 0;
        reset                 = 1'b1;
        bus.proc2Imem_command = BUS_NONE;
        bus.proc2Imem_addr    = '0;
        bus.proc2Dmem_command = BUS_NONE;
        bus.proc2Dmem_addr    = '0;
        bus.proc2Dmem_data    = '0;
        bus.squash_imem       = 1'b0;
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = '0;
        bus.mem2proc_data     = '0;

        // Field order: rst, icmd, iaddr, dcmd, daddr, ddata, squash, resp, rtag, rdata,
        //              ecmd, eaddr, edata, eiresp, edresp, eidata, eitag, eddata, edtag, eerr
        // Reset held with both sides requesting: everything must read as zero.
        vecs.push_back(vec_t'{1, L, 'h100, S, 'h200, 'h5A, 0, 3, 3, 'h11,  N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, L, 'h100, S, 'h200, 'h5A, 0, 3, 3, 'h11,  N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // I-only load, tag 3 returns five cycles later, then a repeat return on 3 is an orphan.
        vecs.push_back(vec_t'{0, L, 'h100, N, 0, 0, 0, 3, 0, 0,             L, 'h100, 0, 3, 0, 0, 0, 0, 0, 0});
        for (int k = 0; k < 4; k++)
            vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 0, 0,             N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 3, 'hDEAD_BEEF_0000_0001,
                              N, 0, 0, 0, 0, 'hDEAD_BEEF_0000_0001, 3, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 3, 'h55,              N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{1, N, 0, N, 0, 0, 0, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // Both load: D wins four times, the fifth is a forced I grant, then D wins again.
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 4, 0, 0,      L, 'h200, 'h99, 0, 4, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 6, 0, 0,      L, 'h200, 'h99, 0, 6, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 8, 0, 0,      L, 'h200, 'h99, 0, 8, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 9, 0, 0,      L, 'h200, 'h99, 0, 9, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 10, 0, 0,     L, 'h100, 0, 10, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h100, L, 'h200, 'h99, 0, 11, 0, 0,     L, 'h200, 'h99, 0, 11, 0, 0, 0, 0, 0});
        // I load on tag 5, squash, return on 5 dropped; D tag 4 still delivered.
        vecs.push_back(vec_t'{0, L, 'h108, N, 0, 0, 0, 5, 0, 0,             L, 'h108, 0, 5, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 1, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 5, 'hAAAA,            N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 4, 'h4444,            N, 0, 0, 0, 0, 0, 0, 'h4444, 4, 0});
        // Squash cycle: returning I tag 12 delivered, I tag 13 allocated already squashed.
        vecs.push_back(vec_t'{0, L, 'h110, N, 0, 0, 0, 12, 0, 0,            L, 'h110, 0, 12, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h118, N, 0, 0, 1, 13, 12, 'hC,         L, 'h118, 0, 13, 0, 'hC, 12, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 13, 'hD,              N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 10, 'hE,              N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // D owns tag 2; its return coincides with a new I allocation of tag 2.
        vecs.push_back(vec_t'{0, N, 0, L, 'h208, 0, 0, 2, 0, 0,             L, 'h208, 0, 0, 2, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, L, 'h120, N, 0, 0, 0, 2, 2, 'h2222,        L, 'h120, 0, 2, 0, 0, 0, 'h2222, 2, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 2, 'h3333,            N, 0, 0, 0, 0, 'h3333, 2, 0, 0, 0});
        // D store on tag 7 is forwarded untracked; its later return is an orphan.
        vecs.push_back(vec_t'{0, N, 0, S, 'h300, 'h1234, 0, 7, 0, 0,        S, 'h300, 'h1234, 0, 7, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 7, 'h77,              N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 1});

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset with three loads outstanding: old tags come back as orphans.
        hand.push_back(vec_t'{1, N, 0, N, 0, 0, 0, 0, 0, 0,                 N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{0, L, 'h400, N, 0, 0, 0, 1, 0, 0,             L, 'h400, 0, 1, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{0, N, 0, L, 'h500, 0, 0, 14, 0, 0,            L, 'h500, 0, 0, 14, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{0, L, 'h408, N, 0, 0, 0, 15, 0, 0,            L, 'h408, 0, 15, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{1, L, 'h410, S, 'h600, 'hBEEF, 0, 5, 1, 'h11, N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{1, L, 'h410, S, 'h600, 'hBEEF, 0, 5, 1, 'h11, N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 1, 'h11,              N, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        hand.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 14, 'h22,             N, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        hand.push_back(vec_t'{0, N, 0, N, 0, 0, 0, 0, 15, 'h33,             N, 0, 0, 0, 0, 0, 0, 0, 0, 1});

        foreach (hand[i]) apply(hand[i], 100 + i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction cache controller, the data cache controller and the single-ported main memory bus.
- Each cycle it grants the bus to one requester and passes memory's accept tag back to the granted side.
- It records which side owns each outstanding tag and steers each returning data beat to its owner.
- It also provides anti-starvation for instruction fetch and can squash in-flight fetches on a branch.

Parameters:
- TAG_W, 4, memory transaction tag width; tag 0 means "no tag / not accepted".
- ADDR_W, 32, address width (XLEN).
- DATA_W, 64, memory data beat width.
- STARVE_LIMIT, 4, consecutive cycles the I-side may be denied before it gets a forced grant.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- proc2Imem_command  in  2  I-side command (BUS_NONE/BUS_LOAD); the I-side never stores
- proc2Imem_addr  in  ADDR_W  I-side 8-byte-aligned address
- proc2Dmem_command  in  2  D-side command (BUS_NONE/BUS_LOAD/BUS_STORE)
- proc2Dmem_addr  in  ADDR_W  D-side address
- proc2Dmem_data  in  DATA_W  D-side store data
- squash_imem  in  1  branch taken; drop all I-side outstanding loads
- mem2proc_response  in  TAG_W  memory accept tag (0 = rejected)
- mem2proc_data  in  DATA_W  memory return data
- mem2proc_tag  in  TAG_W  tag of the returning data (0 = none)
- proc2mem_command  out  2  bus command
- proc2mem_addr  out  ADDR_W  bus address
- proc2mem_data  out  DATA_W  bus store data
- Imem2proc_response  out  TAG_W  accept tag to the I-side
- Imem2proc_data  out  DATA_W  return data to the I-side
- Imem2proc_tag  out  TAG_W  return tag to the I-side
- Dmem2proc_response  out  TAG_W  accept tag to the D-side
- Dmem2proc_data  out  DATA_W  return data to the D-side
- Dmem2proc_tag  out  TAG_W  return tag to the D-side
- orphan_tag_err  out  1  sticky flag: data returned for a tag with no recorded owner

Behaviour:
- State:
  - owner table with 2^TAG_W entries, each {valid, owner (I/D), squashed}.
  - starve_cnt counter, width clog2(STARVE_LIMIT+1).
- Reset (synchronous):
  - All table entries invalid; starve_cnt = 0; orphan_tag_err = 0.
  - While reset is high, proc2mem_command = BUS_NONE and all outputs = 0.
- Arbitration (combinational, same cycle):
  - Default: the D-side wins when its command != BUS_NONE.
  - Forced I-grant: the I-side wins when its command is BUS_LOAD and starve_cnt == STARVE_LIMIT.
  - The granted side's command/addr/data drive the bus. The non-granted side's data output is zeroed.
  - proc2mem_addr = 0 and proc2mem_data = 0 when nothing is granted.
  - The granted side receives mem2proc_response the same cycle. The non-granted side receives response 0, i.e. a rejection, and retries.
- starve_cnt update (clocked):
  - Increments, saturating at STARVE_LIMIT, when the I-side requests and is not granted.
  - Clears when the I-side is granted or not requesting.
- Allocate (clocked): when the granted command is BUS_LOAD and mem2proc_response != 0, entry[mem2proc_response] <= {1, owner, 0}. Stores never allocate.
- Return (combinational from the registered table):
  - When mem2proc_tag != 0 and the entry is valid and not squashed, forward mem2proc_data/mem2proc_tag to the owner's outputs. The other side's return outputs stay 0.
  - The entry clears at the clock edge.
  - A valid but squashed entry: data is dropped, entry cleared.
  - An invalid entry: data is dropped and orphan_tag_err is set (sticky until reset).
- Squash: squash_imem sets squashed on every valid I-owned entry at the clock edge.
  - Same-cycle return of an I tag while squash_imem is high: that beat is still delivered.
  - An I allocation in the same cycle as squash_imem is squashed on entry.
- Simultaneous allocate and return of the same tag: the return consumes the old entry and the allocation writes the new one. Allocation wins the final state.
- Latency:
  - Request to bus and accept tag back: 0 cycles, combinational.
  - Return data to owner: 0 cycles after mem2proc_tag.
  - Table state is visible the cycle after allocation.
- D-side stores are passed through the same way as loads. Their response tag is forwarded, with no table entry.

Decomposition:
- Shared package: BUS_NONE/BUS_LOAD/BUS_STORE command enum; owner_e {OWN_I, OWN_D}; tag_entry_t struct {valid, owner, squashed}.
- One sub-module, mem_tag_table: owner table with an allocate port, a lookup/retire port, and a squash-all-I input.
- The arbiter and starve counter stay in the top module.

Test Plan:
- I-only load, addr 0x100, response 3, data 0xDEAD_BEEF_0000_0001 on tag 3 five cycles later -> Imem2proc_response = 3 the same cycle; Imem2proc_data/tag delivered; D-side return outputs 0; entry 3 cleared.
- I and D load together, D addr 0x200 -> bus carries 0x200; Dmem2proc_response = tag; Imem2proc_response = 0. Hold both requests 5 cycles -> I-side granted on cycle 5 (STARVE_LIMIT = 4); starve_cnt returns to 0.
- I load gets tag 5, then squash_imem, then tag 5 returns -> no I or D data delivered; orphan_tag_err stays 0; entry 5 invalid.
- D store to 0x300, data 0x1234, response 7 -> bus shows BUS_STORE/0x300/0x1234; Dmem2proc_response = 7; no table entry. Later mem2proc_tag = 7 -> orphan_tag_err = 1.
- Tag 2 returns for the D-side while a new I load gets response 2 in the same cycle -> D receives the data; entry 2 becomes I-owned. Later return on tag 2 goes to the I-side.
- Reset asserted with 3 entries outstanding -> command BUS_NONE during reset; all entries invalid afterwards; returns on the old tags set orphan_tag_err.
